// File: rtl/inert_spi_seq.sv
// Inertial sensor SPI sequencer: power-up wait, three config writes, then one yaw read pair
// (low byte, then high byte) for each data-ready interrupt.
module inert_spi_seq #(
    parameter int unsigned INIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    localparam logic [INIT_W-1:0] TimerMax  = '1;
    localparam logic [15:0]       CmdIntCfg = 16'h0D02;
    localparam logic [15:0]       CmdOdr    = 16'h1160;
    localparam logic [15:0]       CmdRound  = 16'h1440;
    localparam logic [15:0]       CmdRdYawL = 16'hA600;
    localparam logic [15:0]       CmdRdYawH = 16'hA700;

    typedef enum logic [2:0] {
        StInitWait,
        StCfg1,
        StCfg2,
        StCfg3,
        StIdle,
        StRdL,
        StRdH
    } state_e;

    state_e            state_q, state_d;
    logic [INIT_W-1:0] timer_q, timer_d;
    logic              wrt_q, wrt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [7:0]        low_q, low_d;
    logic [15:0]       yaw_q, yaw_d;
    logic              vld_q, vld_d;
    logic              int_ff1_q, int_ff2_q;

    // INT comes straight from the sensor pin, so it is double-flopped before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
        end else begin
            int_ff1_q <= INT;
            int_ff2_q <= int_ff1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInitWait;
            timer_q <= '0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            low_q   <= 8'h00;
            yaw_q   <= 16'h0000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            low_q   <= low_d;
            yaw_q   <= yaw_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        low_d   = low_q;
        yaw_d   = yaw_q;
        vld_d   = 1'b0;
        unique case (state_q)
            StInitWait: begin
                // Timer stops at all-ones, so it never wraps after leaving this state.
                if (timer_q == TimerMax) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CmdIntCfg;
                    state_d = StCfg1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCfg1: begin
                if (done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CmdOdr;
                    state_d = StCfg2;
                end
            end
            StCfg2: begin
                if (done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRound;
                    state_d = StCfg3;
                end
            end
            StCfg3: begin
                if (done) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (int_ff2_q) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRdYawL;
                    state_d = StRdL;
                end
            end
            StRdL: begin
                if (done) begin
                    low_d   = rd_data[7:0];
                    wrt_d   = 1'b1;
                    cmd_d   = CmdRdYawH;
                    state_d = StRdH;
                end
            end
            StRdH: begin
                if (done) begin
                    yaw_d   = {rd_data[7:0], low_q};
                    vld_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StInitWait;
        endcase
    end

    assign wrt    = wrt_q;
    assign cmd    = cmd_q;
    assign yaw_rt = yaw_q;
    assign vld    = vld_q;

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq with a small SPI monarch model that answers each wrt.
module tb_inert_spi_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;

    int vectors = 0;
    int miscompares = 0;
    int n;

    inert_spi_seq #(.INIT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .yaw_rt  (yaw_rt),
        .vld     (vld)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the next wrt pulse, then check the command it carries.
    task automatic wait_wrt(input string tag, input logic [15:0] exp_cmd);
        int k = 0;
        while (wrt !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        check({tag, " wrt"}, {31'd0, wrt}, 32'd1);
        check({tag, " cmd"}, {16'd0, cmd}, {16'd0, exp_cmd});
    endtask

    // Answer the outstanding transaction after gap cycles; no wrt may appear meanwhile.
    task automatic respond(input string tag, input logic [15:0] rdv, input int gap);
        int extra = 0;
        repeat (gap) begin
            tick();
            if (wrt === 1'b1) extra++;
        end
        check({tag, " quiet"}, extra, 0);
        done    = 1'b1;
        rd_data = rdv;
        tick();
        done    = 1'b0;
        rd_data = 16'hDEAD;
    endtask

    task automatic count_wrt(input string tag, input int cycles);
        int extra = 0;
        repeat (cycles) begin
            tick();
            if (wrt === 1'b1) extra++;
        end
        check({tag, " no wrt"}, extra, 0);
    endtask

    task automatic cycles_to_wrt(output int k);
        k = 0;
        while (wrt !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        INT     = 1'b0;
        done    = 1'b0;
        rd_data = 16'h0000;
        repeat (3) tick();
        check("reset wrt", {31'd0, wrt}, 32'd0);
        check("reset cmd", {16'd0, cmd}, 32'h0);
        check("reset yaw", {16'd0, yaw_rt}, 32'h0);
        check("reset vld", {31'd0, vld}, 32'd0);

        // Power-up: timer counts 1..15 on the first 15 edges, wrt rises on the 16th.
        rst_n = 1'b1;
        cycles_to_wrt(n);
        check("init latency", n, 16);
        wait_wrt("cfg1", 16'h0D02);
        respond("cfg1", 16'h0000, 20);
        wait_wrt("cfg2", 16'h1160);
        respond("cfg2", 16'h0000, 20);
        wait_wrt("cfg3", 16'h1440);
        respond("cfg3", 16'h0000, 20);
        count_wrt("idle int0", 30);

        // Single read pair; upper bytes of rd_data must be ignored.
        INT = 1'b1;
        cycles_to_wrt(n);
        check("int latency", n, 3);
        wait_wrt("rdl", 16'hA600);
        respond("rdl", 16'h33A5, 20);
        INT = 1'b0;
        wait_wrt("rdh", 16'hA700);
        respond("rdh", 16'h775A, 20);
        check("yaw1 vld", {31'd0, vld}, 32'd1);
        check("yaw1 val", {16'd0, yaw_rt}, 32'h5AA5);
        tick();
        check("yaw1 vld drop", {31'd0, vld}, 32'd0);
        check("yaw1 hold", {16'd0, yaw_rt}, 32'h5AA5);
        count_wrt("after pair", 20);

        // INT held high: second pair starts the cycle after vld.
        INT = 1'b1;
        wait_wrt("rdl b2b", 16'hA600);
        respond("rdl b2b", 16'h0022, 20);
        wait_wrt("rdh b2b", 16'hA700);
        respond("rdh b2b", 16'h0011, 20);
        check("yaw2 vld", {31'd0, vld}, 32'd1);
        check("yaw2 val", {16'd0, yaw_rt}, 32'h1122);
        tick();
        check("yaw2 vld drop", {31'd0, vld}, 32'd0);
        check("b2b wrt", {31'd0, wrt}, 32'd1);
        check("b2b cmd", {16'd0, cmd}, 32'hA600);
        respond("rdl pulse", 16'h0044, 20);
        wait_wrt("rdh pulse", 16'hA700);
        INT = 1'b0;
        repeat (3) tick();
        INT = 1'b1;
        tick();
        INT = 1'b0;
        respond("rdh pulse", 16'h0033, 15);
        check("yaw3 vld", {31'd0, vld}, 32'd1);
        check("yaw3 val", {16'd0, yaw_rt}, 32'h3344);
        count_wrt("no queued int", 20);

        // Spurious done in IDLE.
        done    = 1'b1;
        rd_data = 16'hFFFF;
        tick();
        done    = 1'b0;
        check("spur wrt", {31'd0, wrt}, 32'd0);
        check("spur vld", {31'd0, vld}, 32'd0);
        check("spur yaw", {16'd0, yaw_rt}, 32'h3344);
        count_wrt("spur", 10);
        INT = 1'b1;
        cycles_to_wrt(n);
        check("spur still idle", n, 3);
        check("spur rd cmd", {16'd0, cmd}, 32'hA600);

        // Asynchronous reset while in RD_L.
        repeat (4) tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst wrt", {31'd0, wrt}, 32'd0);
        check("arst cmd", {16'd0, cmd}, 32'h0);
        check("arst yaw", {16'd0, yaw_rt}, 32'h0);
        check("arst vld", {31'd0, vld}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        cycles_to_wrt(n);
        check("reinit latency", n, 16);
        wait_wrt("recfg1", 16'h0D02);
        respond("recfg1", 16'h0000, 20);
        wait_wrt("recfg2", 16'h1160);
        respond("recfg2", 16'h0000, 20);
        wait_wrt("recfg3", 16'h1440);
        respond("recfg3", 16'h0000, 20);
        wait_wrt("re rdl", 16'hA600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
